// File: rtl/mem_stage.sv
// Pipeline memory stage: EX/MEM register, data-memory access FSM,
// load alignment/extension and store byte-laning (big-endian lanes).
module mem_stage #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          validin,
    input  logic [31:0]   aluresult,
    input  logic [31:0]   storedata,
    input  logic [4:0]    rwin_ex,
    input  logic          regwrite_ex,
    input  logic          memread,
    input  logic          memwrite,
    input  logic [1:0]    memsize,
    input  logic          memsigned,
    input  logic [1:0]    fpoint_ex,
    input  logic [31:0]   delayslot2_ex,
    input  logic          jal_ex,
    output logic          stall,
    output logic          memexc,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [AW-1:0] dmem_addr,
    output logic [31:0]   dmem_wdata,
    output logic [3:0]    dmem_be,
    input  logic [31:0]   dmem_rdata,
    input  logic          dmem_ack,
    output logic [4:0]    rwin,
    output logic [31:0]   busWin,
    output logic          regwritein,
    output logic [1:0]    fpointin,
    output logic [31:0]   delayslot2in,
    output logic          jalin
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        qvalid;
    logic [31:0] qalu;
    logic [31:0] qsd;
    logic [4:0]  qrw;
    logic        qregwrite;
    logic        qmemread;
    logic        qmemwrite;
    logic [1:0]  qsize;
    logic        qsigned;
    logic [1:0]  qfpoint;
    logic [31:0] qds2;
    logic        qjal;

    logic [1:0]  state;
    logic [31:0] ldata;

    logic        memop;
    logic        mis;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic [1:0]  a;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] load_c;

    assign a       = qalu[1:0];
    assign is_byte = (qsize == 2'b00);
    assign is_half = (qsize == 2'b01);
    assign is_word = qsize[1];
    assign memop   = qvalid & (qmemread | qmemwrite);
    assign mis     = memop & ((is_half & a[0]) |
                              (is_word & (a != 2'b00)));
    assign memexc  = mis;

    // Stall while the access is being set up or is outstanding.
    always_comb begin
        stall = 1'b0;
        unique case (state)
            S_IDLE:  stall = memop & ~mis;
            S_REQ:   stall = 1'b1;
            S_DONE:  stall = 1'b0;
            default: stall = 1'b0;
        endcase
    end

    // EX/MEM register: captures whenever the stage is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qvalid    <= 1'b0;
            qalu      <= '0;
            qsd       <= '0;
            qrw       <= '0;
            qregwrite <= 1'b0;
            qmemread  <= 1'b0;
            qmemwrite <= 1'b0;
            qsize     <= '0;
            qsigned   <= 1'b0;
            qfpoint   <= '0;
            qds2      <= '0;
            qjal      <= 1'b0;
        end else if (!stall) begin
            qvalid    <= validin;
            qalu      <= aluresult;
            qsd       <= storedata;
            qrw       <= rwin_ex;
            qregwrite <= regwrite_ex;
            qmemread  <= memread;
            qmemwrite <= memwrite;
            qsize     <= memsize;
            qsigned   <= memsigned;
            qfpoint   <= fpoint_ex;
            qds2      <= delayslot2_ex;
            qjal      <= jal_ex;
        end
    end

    // Store laning: replicate data, enable only the addressed lanes.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = qsd;
        if (is_byte) begin
            wdata_c = {4{qsd[7:0]}};
            unique case (a)
                2'b00:   be_c = 4'b1000;
                2'b01:   be_c = 4'b0100;
                2'b10:   be_c = 4'b0010;
                default: be_c = 4'b0001;
            endcase
        end else if (is_half) begin
            wdata_c = {2{qsd[15:0]}};
            be_c    = a[1] ? 4'b0011 : 4'b1100;
        end
    end

    // Load alignment: right-justify the addressed lane, then extend.
    always_comb begin
        load_c = ldata;
        if (is_byte) begin
            logic [7:0] b;
            unique case (a)
                2'b00:   b = ldata[31:24];
                2'b01:   b = ldata[23:16];
                2'b10:   b = ldata[15:8];
                default: b = ldata[7:0];
            endcase
            load_c = {{24{qsigned & b[7]}}, b};
        end else if (is_half) begin
            logic [15:0] h;
            h      = a[1] ? ldata[15:0] : ldata[31:16];
            load_c = {{16{qsigned & h[15]}}, h};
        end
    end

    // Access FSM with registered request and payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            ldata      <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (memop && !mis) begin
                        state      <= S_REQ;
                        dmem_req   <= 1'b1;
                        dmem_we    <= qmemwrite;
                        dmem_addr  <= {qalu[AW-1:2], 2'b00};
                        dmem_wdata <= wdata_c;
                        dmem_be    <= be_c;
                    end
                end
                S_REQ: begin
                    if (dmem_ack) begin
                        ldata    <= dmem_rdata;
                        dmem_req <= 1'b0;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state    <= S_IDLE;
                    dmem_req <= 1'b0;
                end
            endcase
        end
    end

    assign busWin       = qmemread ? load_c : qalu;
    assign regwritein   = qvalid & qregwrite & ~mis &
                          ~(memop & (state != S_DONE));
    assign rwin         = qrw;
    assign fpointin     = qfpoint;
    assign delayslot2in = qds2;
    assign jalin        = qjal;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline memory stage: holds the EX/MEM register, runs the data-memory access FSM, aligns and extends loads, and lanes stores.
- Drives the writeback-stage inputs (rwin, busWin, regwritein, fpointin, delayslot2in, jalin) combinationally from its registered state.
- The writeback stage registers those inputs on the next edge.
- Stalls upstream stages while a data-memory access is in flight.

Parameters:
- AW, 32, data-memory address width.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- validin  in  1  EX stage presents a real instruction.
- aluresult  in  32  ALU result or effective address.
- storedata  in  32  rt value for stores.
- rwin_ex  in  5  destination register.
- regwrite_ex  in  1  instruction writes a register.
- memread  in  1  load.
- memwrite  in  1  store.
- memsize  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- memsigned  in  1  sign-extend loads.
- fpoint_ex  in  2  FP register-file select, passed through.
- delayslot2_ex  in  32  jal link value, passed through.
- jal_ex  in  1  jal, passed through.
- stall  out  1  hold upstream pipeline registers.
- memexc  out  1  misaligned-access pulse.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  write enable.
- dmem_addr  out  AW  word-aligned address (low 2 bits = 0).
- dmem_wdata  out  32  laned store data.
- dmem_be  out  4  byte enables; bit3 = bits 31:24.
- dmem_rdata  in  32  read data, valid in the dmem_ack cycle.
- dmem_ack  in  1  access complete, single-cycle pulse.
- rwin  out  5  to writeback stage.
- busWin  out  32  to writeback stage.
- regwritein  out  1  to writeback stage.
- fpointin  out  2  to writeback stage.
- delayslot2in  out  32  to writeback stage.
- jalin  out  1  to writeback stage.

Behaviour:
- Reset: all EX/MEM q-registers 0, state IDLE, dmem_req 0, load-data register 0. All outputs 0.
- Reset mid-access: abandons the access immediately; any later dmem_ack is ignored.
- Capture: on a clk edge with stall=0, every *_ex input and validin loads into the q-registers. With stall=1 the q-registers hold and inputs are ignored.
- memop = qvalid & (qmemread | qmemwrite).
- Misalignment: mis = memop & ((size half & addr[0]) | (size word & addr[1:0]!=0)).
- Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24.
- FSM, state IDLE:
  - memop & !mis: stall=1; next edge latches dmem_req=1, we, addr, wdata, be; go to REQ.
  - Otherwise stall=0.
- FSM, state REQ:
  - stall=1; dmem_req and payload held stable.
  - On a dmem_ack edge: dmem_rdata is latched into the load register, dmem_req clears, go to DONE.
  - No ack: stay in REQ indefinitely.
- FSM, state DONE:
  - stall=0; result presented; next instruction captured; go to IDLE.
- Stores:
  - Byte: data[7:0] replicated on all 4 lanes; be one-hot by addr[1:0] (00→1000).
  - Half: data[15:0] replicated on both halves; be 1100 if addr[1]=0, else 0011.
  - Word: be 1111.
- Loads: selected lane is right-justified, then zero- or sign-extended per memsigned. A word load ignores memsigned.
- busWin: load value when qmemread, else qaluresult.
- regwritein = qvalid & qregwrite & !mis & !(memop & state!=DONE). Bubbles are delivered to the writeback stage while stalled.
- rwin, fpointin, delayslot2in, jalin are driven from the q-registers unconditionally.
- memexc = mis, high for exactly one cycle:
  - no memory request is issued;
  - the register write is suppressed;
  - the FSM stays in IDLE.
- Latency:
  - Non-memory instruction is visible at the writeback inputs in the cycle after capture.
  - Memory instruction takes 2 + (ack wait) cycles: IDLE cycle, ≥1 REQ cycle, DONE cycle.
- Back-to-back memory ops: the capture in DONE re-enters the IDLE→REQ path with no lost cycle.

Test Plan:
- Reset: assert rst_n=0 mid-REQ with dmem_req=1 → dmem_req, stall, regwritein = 0 asynchronously. A later ack is ignored; state IDLE.
- ALU op: aluresult=0x1234_5678, rwin_ex=5, regwrite=1 → next cycle busWin=0x12345678, rwin=5, regwritein=1, stall=0, no dmem_req.
- Signed byte load: addr 0x101, ack after 3 REQ cycles, rdata 0x00F0_0000 →
  - stall high for 5 cycles, regwritein=0 throughout;
  - DONE cycle: busWin=0xFFFFFFF0, regwritein=1.
- Half store: addr 0x202, storedata 0xAAAA_BEEF → dmem_addr=0x200, be=0011, wdata=0xBEEFBEEF, we=1; regwritein stays 0.
- Misaligned word load: addr 0x0000_0006 → memexc one cycle, no dmem_req, regwritein=0, stall=0.
- Back-to-back loads with ack in first REQ cycle: each op stalls exactly 2 cycles; results 0x11111111 then 0x22222222 delivered on consecutive DONE cycles.
